wtm_result_collector: RTL and testbench

- Sits directly downstream of the pipelined 16x16 Wallace-tree multiplier and consumes its 33-bit product bus.
- The multiplier has no valid or stall signals, so this block tracks every issued operand pair through a LATENCY-deep valid/tag delay line.
- It captures each product in the exact cycle it emerges and buffers it in a FIFO with a valid/ready output.
- It back-pressures the issuer with credit-based issue_ready, so no product is ever lost.

---
 rtl/wtm_result_collector.sv | 131 +++++++++++++
 tb/tb_wtm_result_collector.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/wtm_result_collector.sv
// wtm_result_collector
// Collects products from a pipelined 16x16 Wallace-tree multiplier that has
// no valid/stall handshake of its own. Every accepted operand pair is tracked
// through a LATENCY-deep {valid, tag} delay line so that the product is
// sampled in exactly the cycle it appears on prod_in. Captured results are
// buffered in a DEPTH-entry circular FIFO with a valid/ready output, and the
// issuer is throttled by credits so the FIFO can never overflow.
//
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   issue_valid    operand pair presented to the multiplier this cycle
//   issue_tag      opaque id travelling alongside the operation
//   issue_ready    a credit is available (registered-state decode only)
//   prod_in        33-bit multiplier product bus
//   out_valid      FIFO head holds a result
//   out_ready      downstream consumes the head
//   out_data       product at the FIFO head
//   out_tag        tag at the FIFO head
//   count          FIFO occupancy
//   ovf_err        sticky: a capture found the FIFO full with no pop
module wtm_result_collector #(
  parameter int LATENCY = 6,
  parameter int DEPTH   = 8,
  parameter int TAG_W   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid,
  input  logic [TAG_W-1:0]           issue_tag,
  output logic                       issue_ready,
  input  logic [32:0]                prod_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [32:0]                out_data,
  output logic [TAG_W-1:0]           out_tag,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DepthC    = CW'(DEPTH);
  localparam logic [CW:0]   DepthWide = (CW + 1)'(DEPTH);

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [TAG_W-1:0]   tagLine_q [LATENCY];

  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic          ovf_q, ovf_d;

  logic [32:0]      dataMem [DEPTH];
  logic [TAG_W-1:0] tagMem  [DEPTH];

  logic          acc;
  logic          cap;
  logic          pop;
  logic          push;
  logic          full;
  logic [CW:0]   creditsUsed;

  // Credits cover both buffered results and operations still inside the
  // multiplier, so a slot is reserved for every product before it is issued.
  assign creditsUsed = {1'b0, count_q} + {1'b0, inflight_q};
  assign issue_ready = creditsUsed < DepthWide;

  assign out_valid = (count_q != '0);
  assign out_data  = dataMem[rdPtr_q];
  assign out_tag   = tagMem[rdPtr_q];
  assign count     = count_q;
  assign ovf_err   = ovf_q;

  // Next-state bookkeeping: delay-line shift, pointer/counter updates and the
  // overflow guard. A pop in the same cycle frees the slot a full capture needs.
  always_comb begin
    acc  = issue_valid & issue_ready;
    cap  = vld_q[LATENCY-1];
    pop  = out_valid & out_ready;
    full = (count_q == DepthC);
    push = cap & (~full | pop);

    vld_d[0] = acc;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
    end

    wrPtr_d    = push ? wrPtr_q + AW'(1) : wrPtr_q;
    rdPtr_d    = pop  ? rdPtr_q + AW'(1) : rdPtr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    inflight_d = inflight_q + CW'(acc) - CW'(cap);
    ovf_d      = ovf_q | (cap & full & ~pop);
  end

  // Control state; clearing the valids discards any products still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q      <= '0;
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      vld_q      <= vld_d;
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      ovf_q      <= ovf_d;
    end
  end

  // Tags only matter where the matching valid is set, so they need no reset.
  always_ff @(posedge clk) begin
    tagLine_q[0] <= issue_tag;
    for (int i = 1; i < LATENCY; i++) begin
      tagLine_q[i] <= tagLine_q[i-1];
    end
  end

  // Result storage: the product bus is sampled in the capture cycle itself.
  always_ff @(posedge clk) begin
    if (push) begin
      dataMem[wrPtr_q] <= prod_in;
      tagMem[wrPtr_q]  <= tagLine_q[LATENCY-1];
    end
  end

endmodule

// File: tb/tb_wtm_result_collector.sv
// tb_wtm_result_collector
// Drives wtm_result_collector together with a behavioural model of the
// multiplier (a product delay of LATENCY cycles, garbage when idle) and
// compares every output each cycle against a queue-based reference model.
module tb_wtm_result_collector;

  localparam int LAT = 6;
  localparam int DEP = 8;
  localparam int TW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid;
  logic [TW-1:0] issue_tag;
  logic          issue_ready;
  logic [32:0]   prod_in;
  logic          out_valid;
  logic          out_ready;
  logic [32:0]   out_data;
  logic [TW-1:0] out_tag;
  logic [3:0]    count;
  logic          ovf_err;

  always #5 clk = ~clk;

  wtm_result_collector #(.LATENCY(LAT), .DEPTH(DEP), .TAG_W(TW)) dut (
    .clk(clk),
    .rst(rst),
    .issue_valid(issue_valid),
    .issue_tag(issue_tag),
    .issue_ready(issue_ready),
    .prod_in(prod_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_tag(out_tag),
    .count(count),
    .ovf_err(ovf_err)
  );

  typedef struct {
    int          due;
    logic [32:0] prod;
    logic [3:0]  tag;
  } pend_t;

  typedef struct {
    logic [32:0] prod;
    logic [3:0]  tag;
  } res_t;

  pend_t       pendQ[$];
  res_t        fifoQ[$];
  logic [32:0] mulPipe [LAT];
  logic        expOvf;
  int          cyc;
  int          total;
  int          bad;
  int          dutAccepts;
  int          maxCount;

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Multiplier stand-in: real product for presented operands, noise otherwise.
  task automatic shiftMultiplier(input logic iv, input logic [15:0] a, input logic [15:0] b);
    for (int i = LAT - 1; i > 0; i--) mulPipe[i] = mulPipe[i-1];
    if (iv) mulPipe[0] = {17'd0, a} * {17'd0, b};
    else    mulPipe[0] = {1'($urandom), $urandom};
    prod_in = mulPipe[LAT-1];
  endtask

  // Reference model advanced at each clock edge from the inputs held there.
  task automatic modelEdge(input logic iv, input logic [3:0] tag, input logic [15:0] a,
                           input logic [15:0] b, input logic ordy);
    bit    pop;
    bit    rdy;
    pend_t p;
    res_t  r;
    pend_t n;
    pop = (fifoQ.size() != 0) && ordy;
    rdy = (fifoQ.size() + pendQ.size()) < DEP;
    if (pop) void'(fifoQ.pop_front());
    if (pendQ.size() != 0 && pendQ[0].due == cyc) begin
      p = pendQ.pop_front();
      if (fifoQ.size() == DEP) expOvf = 1'b1;
      else begin
        r.prod = p.prod;
        r.tag  = p.tag;
        fifoQ.push_back(r);
      end
    end
    if (iv && rdy) begin
      n.due  = cyc + LAT;
      n.prod = {17'd0, a} * {17'd0, b};
      n.tag  = tag;
      pendQ.push_back(n);
    end
    cyc++;
  endtask

  task automatic checkState();
    checkOutput("out_valid", 64'(out_valid), 64'(fifoQ.size() != 0));
    checkOutput("count", 64'(count), 64'(fifoQ.size()));
    checkOutput("issue_ready", 64'(issue_ready), 64'((fifoQ.size() + pendQ.size()) < DEP));
    checkOutput("ovf_err", 64'(ovf_err), 64'(expOvf));
    if (fifoQ.size() != 0) begin
      checkOutput("out_data", 64'(out_data), 64'(fifoQ[0].prod));
      checkOutput("out_tag", 64'(out_tag), 64'(fifoQ[0].tag));
    end
  endtask

  // One clock cycle: drive at the falling edge, check, then advance models.
  task automatic applyStimulus(input logic iv, input logic [3:0] tag, input logic [15:0] a,
                               input logic [15:0] b, input logic ordy);
    issue_valid = iv;
    issue_tag   = tag;
    out_ready   = ordy;
    checkState();
    if (iv && issue_ready) dutAccepts++;
    if (int'(count) > maxCount) maxCount = int'(count);
    @(posedge clk);
    #1;
    modelEdge(iv, tag, a, b, ordy);
    shiftMultiplier(iv, a, b);
    @(negedge clk);
  endtask

  task automatic doReset(input int n);
    @(negedge clk);
    rst         = 1'b1;
    issue_valid = 1'b0;
    out_ready   = 1'b0;
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_issue_ready", 64'(issue_ready), 64'(1));
    checkOutput("rst_count", 64'(count), 64'(0));
    checkOutput("rst_ovf_err", 64'(ovf_err), 64'(0));
    pendQ.delete();
    fifoQ.delete();
    expOvf = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      shiftMultiplier(1'b0, 16'd0, 16'd0);
      cyc++;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(input int n, input logic ordy);
    repeat (n) applyStimulus(1'b0, 4'($urandom), 16'($urandom), 16'($urandom), ordy);
  endtask

  initial begin
    logic [32:0] expProd;
    total = 0; bad = 0; cyc = 0; expOvf = 1'b0;
    dutAccepts = 0; maxCount = 0;
    rst = 1'b1; issue_valid = 1'b0; issue_tag = '0; out_ready = 1'b0;
    for (int i = 0; i < LAT; i++) mulPipe[i] = {1'($urandom), $urandom};
    prod_in = mulPipe[LAT-1];
    doReset(2);

    // Single operation with the largest operands.
    expProd = 33'h0FFFE0001;
    applyStimulus(1'b1, 4'h3, 16'hFFFF, 16'hFFFF, 1'b0);
    idle(LAT, 1'b0);
    checkOutput("single_valid", 64'(out_valid), 64'(1));
    checkOutput("single_data", 64'(out_data), 64'(expProd));
    checkOutput("single_tag", 64'(out_tag), 64'(3));
    checkOutput("single_count", 64'(count), 64'(1));
    idle(1, 1'b1);
    checkOutput("single_count_after_pop", 64'(count), 64'(0));

    // Noise on the product bus with nothing issued.
    idle(20, 1'b1);
    checkOutput("garbage_valid", 64'(out_valid), 64'(0));
    checkOutput("garbage_count", 64'(count), 64'(0));

    // Back-pressure: credits must stop issue after exactly DEP accepts.
    dutAccepts = 0;
    repeat (DEP + LAT + 4) applyStimulus(1'b1, 4'($urandom), 16'($urandom), 16'($urandom), 1'b0);
    checkOutput("bp_accepts", 64'(dutAccepts), 64'(DEP));
    checkOutput("bp_issue_ready", 64'(issue_ready), 64'(0));
    checkOutput("bp_count", 64'(count), 64'(DEP));
    checkOutput("bp_ovf", 64'(ovf_err), 64'(0));
    idle(DEP + LAT + 4, 1'b1);

    // Streaming at full rate with tags cycling 0..15.
    dutAccepts = 0;
    maxCount   = 0;
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 4'(i), 16'($urandom), 16'($urandom), 1'b1);
    idle(LAT + 2, 1'b1);
    checkOutput("stream_accepts", 64'(dutAccepts), 64'(40));
    checkOutput("stream_count_le1", 64'(maxCount <= 1), 64'(1));
    checkOutput("stream_empty", 64'(count), 64'(0));

    // Accept, capture and pop in one cycle with count=4 and two in flight.
    repeat (4) applyStimulus(1'b1, 4'($urandom), 16'($urandom), 16'($urandom), 1'b0);
    idle(LAT, 1'b0);
    checkOutput("simul_pre_count", 64'(count), 64'(4));
    applyStimulus(1'b1, 4'hA, 16'($urandom), 16'($urandom), 1'b0);
    applyStimulus(1'b1, 4'hB, 16'($urandom), 16'($urandom), 1'b0);
    idle(LAT - 2, 1'b0);
    applyStimulus(1'b1, 4'hC, 16'($urandom), 16'($urandom), 1'b1);
    checkOutput("simul_count", 64'(count), 64'(4));
    checkOutput("simul_ready", 64'(issue_ready), 64'(1));
    idle(DEP + LAT + 4, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      applyStimulus(1'(($urandom % 4) != 0), 4'($urandom), 16'($urandom), 16'($urandom),
                    1'(($urandom % 3) != 0));
    idle(DEP + LAT + 4, 1'b1);

    // Reset while operations are still inside the multiplier.
    repeat (3) applyStimulus(1'b1, 4'($urandom), 16'($urandom), 16'($urandom), 1'b0);
    idle(2, 1'b0);
    doReset(1);
    idle(LAT + 2, 1'b0);
    checkOutput("midrst_valid", 64'(out_valid), 64'(0));
    checkOutput("midrst_count", 64'(count), 64'(0));
    checkOutput("midrst_ready", 64'(issue_ready), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
